// File: rtl/rocket_launch_scheduler.sv
// Rocket slot pool manager: allocates the lowest free slot on a fire edge, retires
// rockets on hit or when off-screen, and rate-limits firing with a frame cooldown.

module rocket_slot #(
  parameter logic signed [10:0] Y_TOP_LIMIT    = -11'sd32,
  parameter logic signed [10:0] Y_BOTTOM_LIMIT = 11'sd479
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               set_i,
  input  logic signed [10:0] rocketY_i,
  input  logic               collision_i,
  output logic               active_o
);
  logic active_q, active_d, aged_q, aged_d, retire;

  // aged_q masks the first active cycle, while the controller still shows its stale position
  always_comb begin
    retire   = active_q & aged_q &
               (collision_i | (rocketY_i < Y_TOP_LIMIT) | (rocketY_i > Y_BOTTOM_LIMIT));
    active_d = set_i | (active_q & ~retire);
    aged_d   = active_q & ~retire;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      active_q <= 1'b0;
      aged_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      aged_q   <= aged_d;
    end
  end

  assign active_o = active_q;
endmodule

module rocket_launch_scheduler #(
  parameter int                 NUM_ROCKETS     = 4,
  parameter int                 COOLDOWN_FRAMES = 8,
  parameter logic signed [8:0]  ROCKET_SPEED    = 9'sh100,
  parameter logic signed [10:0] Y_TOP_LIMIT     = -11'sd32,
  parameter logic signed [10:0] Y_BOTTOM_LIMIT  = 11'sd479
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame_i,
  input  logic                     fireReq_i,
  input  logic signed [10:0]       shooterX_i,
  input  logic signed [10:0]       shooterY_i,
  input  logic [11*NUM_ROCKETS-1:0] rocketY_i,
  input  logic [NUM_ROCKETS-1:0]   collision_i,
  output logic [NUM_ROCKETS-1:0]   isActive_o,
  output logic signed [10:0]       launchX_o,
  output logic signed [10:0]       launchY_o,
  output logic signed [8:0]        launchSpeed_o,
  output logic                     fireDropped_o,
  output logic [3:0]               activeCount_o
);
  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, COOLDOWN} state_t;

  typedef struct packed {
    logic signed [10:0] x;
    logic signed [10:0] y;
    logic signed [8:0]  speed;
  } launch_t;

  state_t                 state_q, state_d;
  launch_t                launch_q, launch_d;
  logic [CW-1:0]          cd_q, cd_d;
  logic [NUM_ROCKETS-1:0] pick_q, pick_d, pick, set_vec, active;
  logic                   fire_q, drop_q, drop_d, req, found;
  logic [3:0]             count_q, count_d;

  assign req = fireReq_i & ~fire_q;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_ROCKETS; i++) begin
      if (!active[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_ROCKETS; i++) count_d = count_d + {3'b000, active[i]};
  end

  always_comb begin
    state_d  = state_q;
    launch_d = launch_q;
    cd_d     = cd_q;
    pick_d   = pick_q;
    drop_d   = 1'b0;
    set_vec  = '0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (found) begin
            pick_d   = pick;
            launch_d = '{x: shooterX_i, y: shooterY_i, speed: ROCKET_SPEED};
            state_d  = LAUNCH;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      LAUNCH: begin
        set_vec = pick_q;
        cd_d    = CW'(COOLDOWN_FRAMES);
        state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (req) drop_d = 1'b1;
        if (startOfFrame_i) begin
          cd_d = cd_q - CW'(1);
          if (cd_q <= CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      launch_q <= '0;
      cd_q     <= '0;
      pick_q   <= '0;
      fire_q   <= 1'b0;
      drop_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
      cd_q     <= cd_d;
      pick_q   <= pick_d;
      fire_q   <= fireReq_i;
      drop_q   <= drop_d;
      count_q  <= count_d;
    end
  end

  for (genvar g = 0; g < NUM_ROCKETS; g++) begin : g_slot
    rocket_slot #(
      .Y_TOP_LIMIT   (Y_TOP_LIMIT),
      .Y_BOTTOM_LIMIT(Y_BOTTOM_LIMIT)
    ) u_slot (
      .clk        (clk),
      .resetN     (resetN),
      .set_i      (set_vec[g]),
      .rocketY_i  (rocketY_i[11*g +: 11]),
      .collision_i(collision_i[g]),
      .active_o   (active[g])
    );
  end

  assign isActive_o    = active;
  assign launchX_o     = launch_q.x;
  assign launchY_o     = launch_q.y;
  assign launchSpeed_o = launch_q.speed;
  assign fireDropped_o = drop_q;
  assign activeCount_o = count_q;
endmodule

// File: tb/tb_rocket_launch_scheduler.sv
// Bench for rocket_launch_scheduler: event/timestamp model of slots and cooldown,
// directed scenarios with literal pins, then a randomized run.
module tb_rocket_launch_scheduler;
  localparam int N  = 4;
  localparam int CD = 8;

  logic clk = 1'b0, resetN = 1'b0, sof = 1'b0, fire = 1'b0;
  logic signed [10:0] shX = '0, shY = '0;
  logic [11*N-1:0] ry = '0;
  logic [N-1:0] coll = '0;
  logic [N-1:0] isActive;
  logic signed [10:0] lX, lY;
  logic signed [8:0] lS;
  logic dropped;
  logic [3:0] cnt;

  always #5 clk = ~clk;

  rocket_launch_scheduler dut (
    .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .fireReq_i(fire),
    .shooterX_i(shX), .shooterY_i(shY), .rocketY_i(ry), .collision_i(coll),
    .isActive_o(isActive), .launchX_o(lX), .launchY_o(lY), .launchSpeed_o(lS),
    .fireDropped_o(dropped), .activeCount_o(cnt)
  );

  int total = 0, bad = 0;
  bit chk_en = 0;

  // Model: per-slot active flag and age in cycles, a pending launch timestamp,
  // and the number of frames still to wait before a fire may be accepted.
  logic [N-1:0] m_act;
  int m_age[N];
  int m_pslot, m_pcyc, m_frames, m_cyc, m_cnt;
  bit m_prev, m_drop;
  logic signed [10:0] m_lx, m_ly;
  logic signed [8:0] m_ls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = '0; m_pslot = -1; m_pcyc = 0; m_frames = 0; m_cnt = 0;
    m_prev = 0; m_drop = 0; m_lx = '0; m_ly = '0; m_ls = '0;
    for (int k = 0; k < N; k++) m_age[k] = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("isActive", 32'(isActive), 32'(m_act));
      chk("launchX", 32'(lX), 32'(m_lx));
      chk("launchY", 32'(lY), 32'(m_ly));
      chk("launchSpeed", 32'(lS), 32'(m_ls));
      chk("fireDropped", 32'(dropped), 32'(m_drop));
      chk("activeCount", 32'(cnt), 32'(m_cnt));
    end
  end

  // Advance one clock: model computes next outputs from the inputs of this cycle.
  task automatic step();
    logic [N-1:0] ret, nact;
    int nage[N];
    int nfr, nps, npc, k0;
    bit req, ndrop;
    logic signed [10:0] nlx, nly, y;
    logic signed [8:0] nls;
    req = fire && !m_prev;
    ret = '0;
    for (int k = 0; k < N; k++) begin
      y = ry[11*k +: 11];
      if (m_act[k] && m_age[k] >= 2 && (coll[k] || y < -32 || y > 479)) ret[k] = 1'b1;
    end
    nact = m_act & ~ret;
    nfr = m_frames; nps = m_pslot; npc = m_pcyc;
    if (m_pslot >= 0 && m_cyc == m_pcyc) begin
      nact[m_pslot] = 1'b1; nfr = CD; nps = -1;
    end else if (m_frames > 0 && sof) nfr = m_frames - 1;
    k0 = -1;
    for (int k = N - 1; k >= 0; k--) if (!m_act[k]) k0 = k;
    nlx = m_lx; nly = m_ly; nls = m_ls; ndrop = 0;
    if (req && m_pslot < 0) begin
      if (m_frames == 0 && k0 >= 0) begin
        nps = k0; npc = m_cyc + 1; nlx = shX; nly = shY; nls = 9'(-256);
      end else ndrop = 1;
    end
    for (int k = 0; k < N; k++) nage[k] = nact[k] ? (m_act[k] ? m_age[k] + 1 : 1) : 0;
    @(posedge clk); #1;
    if (!resetN) model_reset();
    else begin
      m_cnt = $countones(m_act);
      m_act = nact; m_frames = nfr; m_pslot = nps; m_pcyc = npc;
      m_lx = nlx; m_ly = nly; m_ls = nls; m_drop = ndrop; m_prev = fire;
      for (int k = 0; k < N; k++) m_age[k] = nage[k];
    end
    m_cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1; step(); sof = 1'b0; step();
    end
  endtask

  task automatic launch();
    fire = 1'b1; step(); fire = 1'b0; step(); frames(CD);
  endtask

  task automatic do_reset();
    resetN = 1'b0; model_reset(); steps(2); resetN = 1'b1;
  endtask

  initial begin
    int v, r;
    model_reset();
    m_cyc = 0;
    for (int k = 0; k < N; k++) ry[11*k +: 11] = 11'd100;
    chk_en = 1;
    steps(3);
    chk("lit_reset_active", 32'(isActive), 32'h0);
    chk("lit_reset_count", 32'(cnt), 32'h0);
    chk("lit_reset_speed", 32'(lS), 32'h0);
    resetN = 1'b1;

    // launch captures shooter position; held key yields one request
    shX = 11'sd320; shY = 11'sd400;
    fire = 1'b1; step();
    chk("lit_launchX", 32'(lX), 32'(320));
    chk("lit_launchY", 32'(lY), 32'(400));
    chk("lit_speed", 32'(lS), 32'(-256));
    chk("lit_not_yet_active", 32'(isActive), 32'h0);
    step();
    chk("lit_first_active", 32'(isActive), 32'h1);
    steps(100);
    chk("lit_held_key", 32'(isActive), 32'h1);
    fire = 1'b0; step();

    // cooldown rejects, then accepts after the 8th frame
    fire = 1'b1; step();
    chk("lit_cooldown_drop", 32'(dropped), 32'h1);
    fire = 1'b0; step();
    chk("lit_drop_one_cycle", 32'(dropped), 32'h0);
    frames(CD);
    fire = 1'b1; step(); fire = 1'b0; step();
    chk("lit_second_slot", 32'(isActive), 32'h3);

    // async reset mid-cooldown
    resetN = 1'b0; #1;
    chk("lit_async_reset_active", 32'(isActive), 32'h0);
    chk("lit_async_reset_launchX", 32'(lX), 32'h0);
    model_reset(); steps(2); resetN = 1'b1;
    shX = 11'sd10;
    fire = 1'b1; step(); fire = 1'b0; step();
    chk("lit_idle_after_reset", 32'(isActive), 32'h1);

    // full pool, collision frees slot 2, slot reused
    frames(CD); launch(); launch(); launch();
    chk("lit_full", 32'(isActive), 32'hF);
    fire = 1'b1; step(); fire = 1'b0;
    chk("lit_full_drop", 32'(dropped), 32'h1);
    step();
    coll = 4'b0100; step(); coll = '0;
    chk("lit_coll_slot2", 32'(isActive), 32'hB);
    fire = 1'b1; step(); fire = 1'b0; step();
    chk("lit_slot2_reused", 32'(isActive), 32'hF);

    // off-screen retirement and activation-cycle masking
    do_reset();
    fire = 1'b1; step(); fire = 1'b0; step();
    ry[10:0] = -11'sd33; step();
    chk("lit_mask_first_cycle", 32'(isActive), 32'h1);
    step();
    chk("lit_top_retire", 32'(isActive), 32'h0);
    ry[10:0] = 11'sd100;
    frames(CD); launch(); launch();
    ry[21:11] = 11'sd480; step(); ry[21:11] = 11'sd100;
    chk("lit_bottom_retire", 32'(isActive), 32'h1);

    // simultaneous collision and accepted fire
    launch();
    fire = 1'b1; coll = 4'b0010; step(); coll = '0; fire = 1'b0;
    chk("lit_sim_active1", 32'(isActive), 32'h1);
    chk("lit_sim_count2", 32'(cnt), 32'h2);
    step();
    chk("lit_sim_active2", 32'(isActive), 32'h5);
    chk("lit_sim_count1", 32'(cnt), 32'h1);
    step();
    chk("lit_sim_count2b", 32'(cnt), 32'h2);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      sof = ($urandom_range(0, 4) == 0);
      shX = 11'($urandom_range(0, 2047));
      shY = 11'($urandom_range(0, 2047));
      for (int k = 0; k < N; k++) begin
        coll[k] = ($urandom_range(0, 39) == 0);
        r = $urandom_range(0, 19);
        if (r == 0) v = -40 + $urandom_range(0, 15);
        else if (r == 1) v = 470 + $urandom_range(0, 15);
        else v = $urandom_range(0, 400);
        ry[11*k +: 11] = 11'(v);
      end
      step();
    end
    sof = 1'b0; fire = 1'b0; coll = '0;
    steps(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
